// File: rtl/hamming_15_11_rx_deser.sv
// Serial Hamming(15,11) receiver: shifts in LSB-first codewords, corrects single-bit
// errors and presents the 11 data bits on a valid/ready output register.
module hamming_15_11_rx_deser #(
    parameter int CW_W   = 15,
    parameter int DATA_W = 11
) (
    input  logic              clk,
    input  logic              RST,
    input  logic              sin,
    input  logic              sin_valid,
    input  logic              sync_clr,
    output logic [DATA_W-1:0] data_out,
    output logic [3:0]        syndrome,
    output logic              err_corrected,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              overflow,
    output logic [3:0]        bit_cnt
);

    logic [CW_W-1:0]   r_sr;
    logic [3:0]        r_bit_cnt;
    logic [CW_W-1:0]   r_cw_hold;
    logic              r_dec_pend;
    logic [DATA_W-1:0] r_data;
    logic [3:0]        r_syn;
    logic              r_err;
    logic              r_valid;
    logic              r_ovf;

    logic [CW_W-1:0]   w_sr_next;
    logic [3:0]        w_syn;
    logic [CW_W-1:0]   w_fix;
    logic [DATA_W-1:0] w_data;
    logic              w_frame_done;
    logic              w_load_ok;

    assign w_sr_next    = {sin, r_sr[CW_W-1:1]};
    assign w_frame_done = sin_valid && !sync_clr && (r_bit_cnt == 4'd14);
    assign w_load_ok    = !r_valid || out_ready;

    // Syndrome is the XOR of the 1-based positions of all set bits.
    always_comb begin
        w_syn = '0;
        for (int p = 1; p <= CW_W; p++) begin
            if (r_cw_hold[p-1]) w_syn = w_syn ^ 4'(p);
        end
        w_fix = r_cw_hold;
        if (w_syn != 4'd0) w_fix[w_syn - 4'd1] = ~r_cw_hold[w_syn - 4'd1];
    end

    // Data bits live at the non-power-of-two positions 3,5,6,7,9..15.
    assign w_data = {w_fix[14:8], w_fix[6:4], w_fix[2]};

    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            r_sr       <= '0;
            r_bit_cnt  <= '0;
            r_cw_hold  <= '0;
            r_dec_pend <= 1'b0;
        end else begin
            if (sync_clr) begin
                r_sr      <= '0;
                r_bit_cnt <= '0;
            end else if (sin_valid) begin
                r_sr      <= w_sr_next;
                r_bit_cnt <= (r_bit_cnt == 4'd14) ? 4'd0 : r_bit_cnt + 4'd1;
            end
            if (w_frame_done) r_cw_hold <= w_sr_next;
            r_dec_pend <= w_frame_done;
        end
    end

    // Output register: a decode arriving while a word is stalled is dropped.
    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            r_data  <= '0;
            r_syn   <= '0;
            r_err   <= 1'b0;
            r_valid <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_ovf <= 1'b0;
            if (r_dec_pend) begin
                if (w_load_ok) begin
                    r_data  <= w_data;
                    r_syn   <= w_syn;
                    r_err   <= (w_syn != 4'd0);
                    r_valid <= 1'b1;
                end else begin
                    r_ovf <= 1'b1;
                end
            end else if (r_valid && out_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign data_out      = r_data;
    assign syndrome      = r_syn;
    assign err_corrected = r_err;
    assign out_valid     = r_valid;
    assign overflow      = r_ovf;
    assign bit_cnt       = r_bit_cnt;

endmodule

// File: tb/tb_hamming_15_11_rx_deser.sv
// Bench for hamming_15_11_rx_deser: directed vectors plus a randomized scoreboard run.
module tb_hamming_15_11_rx_deser;

    logic        clk = 1'b0;
    logic        RST = 1'b0;
    logic        sin = 1'b0;
    logic        sin_valid = 1'b0;
    logic        sync_clr = 1'b0;
    logic [10:0] data_out;
    logic [3:0]  syndrome;
    logic        err_corrected;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        overflow;
    logic [3:0]  bit_cnt;

    int checks = 0;
    int errors = 0;
    int ovf_cnt = 0;

    hamming_15_11_rx_deser dut (
        .clk(clk), .RST(RST), .sin(sin), .sin_valid(sin_valid), .sync_clr(sync_clr),
        .data_out(data_out), .syndrome(syndrome), .err_corrected(err_corrected),
        .out_valid(out_valid), .out_ready(out_ready), .overflow(overflow), .bit_cnt(bit_cnt)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (overflow) ovf_cnt++;

    // Reference encoder: data bits at non-power-of-two positions, even parity per group.
    function automatic logic [14:0] encode(input logic [10:0] d);
        int dpos [11] = '{3, 5, 6, 7, 9, 10, 11, 12, 13, 14, 15};
        int ppos [4]  = '{1, 2, 4, 8};
        logic [14:0] cw = '0;
        for (int i = 0; i < 11; i++) cw[dpos[i]-1] = d[i];
        for (int j = 0; j < 4; j++) begin
            logic par = 1'b0;
            for (int q = 1; q <= 15; q++)
                if ((q & ppos[j]) != 0 && q != ppos[j]) par ^= cw[q-1];
            cw[ppos[j]-1] = par;
        end
        return cw;
    endfunction

    // Drives 15 bits on consecutive cycles; the last bit is still on the bus on return.
    task automatic send_bits(input logic [14:0] cw);
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            sin = cw[k];
            sin_valid = 1'b1;
        end
    endtask

    // Sends a frame then idles; returns at the negedge where the decode is pending.
    task automatic send_frame(input logic [14:0] cw);
        send_bits(cw);
        @(negedge clk);
        sin_valid = 1'b0;
    endtask

    task automatic test_reset;
        checks++;
        if ({data_out, syndrome, err_corrected, out_valid, overflow, bit_cnt} !== 22'd0) begin
            errors++;
            $display("FAIL reset_outputs got=%h want=0",
                     {data_out, syndrome, err_corrected, out_valid, overflow, bit_cnt});
        end
        @(negedge clk);
        RST = 1'b1;
    endtask

    task automatic test_latency_zero;
        send_frame(15'h0000);
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL t1_early_valid got=%b want=0", out_valid); end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || data_out !== 11'h000 || syndrome !== 4'd0 || err_corrected !== 1'b0) begin
            errors++;
            $display("FAIL t1_word got v=%b d=%h s=%0d e=%b want v=1 d=000 s=0 e=0",
                     out_valid, data_out, syndrome, err_corrected);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL t1_consume got=%b want=0", out_valid); end
    endtask

    task automatic test_vectors;
        logic [14:0] cws [4] = '{15'h0007, 15'h7FFF, 15'h0010, 15'h7F7F};
        logic [10:0] dx  [4] = '{11'h001, 11'h7FF, 11'h000, 11'h7FF};
        logic [3:0]  sx  [4] = '{4'd0, 4'd0, 4'd5, 4'd8};
        for (int i = 0; i < 4; i++) begin
            send_frame(cws[i]);
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || data_out !== dx[i] || syndrome !== sx[i] ||
                err_corrected !== (sx[i] != 4'd0)) begin
                errors++;
                $display("FAIL vec%0d got v=%b d=%h s=%0d e=%b want v=1 d=%h s=%0d e=%b", i,
                         out_valid, data_out, syndrome, err_corrected, dx[i], sx[i], sx[i] != 4'd0);
            end
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
        end
    endtask

    task automatic test_back_to_back;
        int ovf0 = ovf_cnt;
        send_bits(15'h7FFF);
        send_bits(15'h0007);
        @(negedge clk);
        sin_valid = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (ovf_cnt - ovf0 !== 1) begin errors++; $display("FAIL t4_overflow_pulses got=%0d want=1", ovf_cnt - ovf0); end
        checks++;
        if (out_valid !== 1'b1 || data_out !== 11'h7FF) begin
            errors++;
            $display("FAIL t4_held got v=%b d=%h want v=1 d=7ff", out_valid, data_out);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL t4_drop_valid got=%b want=0", out_valid); end
    endtask

    task automatic test_async_reset;
        send_frame(15'h7FFF);
        @(negedge clk);
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            sin = 1'b1;
            sin_valid = 1'b1;
        end
        @(negedge clk);
        sin_valid = 1'b0;
        checks++;
        if (bit_cnt !== 4'd7) begin errors++; $display("FAIL t5_pre_cnt got=%0d want=7", bit_cnt); end
        #2 RST = 1'b0;
        #1;
        checks++;
        if ({data_out, syndrome, err_corrected, out_valid, overflow, bit_cnt} !== 22'd0) begin
            errors++;
            $display("FAIL t5_reset got=%h want=0",
                     {data_out, syndrome, err_corrected, out_valid, overflow, bit_cnt});
        end
        @(negedge clk);
        RST = 1'b1;
        send_frame(15'h0007);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || data_out !== 11'h001 || syndrome !== 4'd0) begin
            errors++;
            $display("FAIL t5_fresh got v=%b d=%h s=%0d want v=1 d=001 s=0", out_valid, data_out, syndrome);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_sync_clr;
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            sin = 1'b1;
            sin_valid = 1'b1;
        end
        @(negedge clk);
        checks++;
        if (bit_cnt !== 4'd9) begin errors++; $display("FAIL t6_cnt9 got=%0d want=9", bit_cnt); end
        sin = 1'b1;
        sin_valid = 1'b1;
        sync_clr = 1'b1;
        @(negedge clk);
        sync_clr = 1'b0;
        sin_valid = 1'b0;
        checks++;
        if (bit_cnt !== 4'd0) begin errors++; $display("FAIL t6_clr got=%0d want=0", bit_cnt); end
        send_frame(15'h0007);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || data_out !== 11'h001 || syndrome !== 4'd0) begin
            errors++;
            $display("FAIL t6_word got v=%b d=%h s=%0d want v=1 d=001 s=0", out_valid, data_out, syndrome);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_random;
        logic [10:0] qd [$];
        logic [3:0]  qs [$];
        bit done = 1'b0;
        int ovf0 = ovf_cnt;
        int got = 0;
        fork
            begin
                for (int f = 0; f < 40; f++) begin
                    logic [10:0] d = 11'($urandom_range(0, 2047));
                    int flip = $urandom_range(0, 15);
                    logic [14:0] cw = encode(d);
                    if (flip != 0) cw[flip-1] = ~cw[flip-1];
                    qd.push_back(d);
                    qs.push_back(4'(flip));
                    for (int k = 0; k < 15; k++) begin
                        @(negedge clk);
                        sin_valid = 1'b0;
                        if ($urandom_range(0, 3) == 0) begin
                            repeat ($urandom_range(1, 3)) @(negedge clk);
                        end
                        sin = cw[k];
                        sin_valid = 1'b1;
                    end
                end
                @(negedge clk);
                sin_valid = 1'b0;
                done = 1'b1;
            end
            begin
                int stall = 0;
                int budget = 0;
                while (!(done && qd.size() == 0) && budget < 5000) begin
                    @(negedge clk);
                    budget++;
                    out_ready = (stall >= 3) ? 1'b1 : ($urandom_range(0, 3) != 0);
                    stall = out_ready ? 0 : stall + 1;
                    if (out_valid && out_ready) begin
                        checks++;
                        if (qd.size() == 0) begin
                            errors++;
                            $display("FAIL t7_extra_word got d=%h want none", data_out);
                        end else begin
                            if (data_out !== qd[0] || syndrome !== qs[0] || err_corrected !== (qs[0] != 4'd0)) begin
                                errors++;
                                $display("FAIL t7_word%0d got d=%h s=%0d e=%b want d=%h s=%0d", got,
                                         data_out, syndrome, err_corrected, qd[0], qs[0]);
                            end
                            void'(qd.pop_front());
                            void'(qs.pop_front());
                        end
                        got++;
                    end
                end
                checks++;
                if (qd.size() != 0) begin errors++; $display("FAIL t7_timeout got pending=%0d want 0", qd.size()); end
            end
        join
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if (ovf_cnt != ovf0) begin errors++; $display("FAIL t7_overflow got=%0d want=0", ovf_cnt - ovf0); end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        test_reset;
        test_latency_zero;
        test_vectors;
        test_back_to_back;
        test_async_reset;
        test_sync_clr;
        test_random;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
